// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: shares one spi_master word stream between two requesters.
// Round-robin arbitration; each transfer is framed as exactly n words in both
// directions (TX gated after n gets, RX routed only to the granted requester).
// Optional build macro: SPI_XFER_GAP_EN adds a G-cycle idle GAP state after
// every transfer. Without it, completion returns straight to IDLE.
//
// Word handshake: the master takes m_in on a cycle where m_get=1 and
// m_empty=0, and that same cycle raises tx_get for the granted requester.
// RX has no backpressure: rx_put is a one-cycle strobe with rx_data that
// the granted requester must accept.
module spi_xfer_arbiter #(
    parameter int W = 8,
    parameter int L = 8,
    parameter int G = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   req,
    input  logic [L-1:0] len0,
    input  logic [L-1:0] len1,
    input  logic [W-1:0] tx_data0,
    input  logic [W-1:0] tx_data1,
    input  logic [1:0]   tx_valid,
    output logic [1:0]   tx_get,
    output logic [W-1:0] rx_data,
    output logic [1:0]   rx_put,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [W-1:0] m_in,
    input  logic         m_get,
    output logic         m_empty,
    input  logic [W-1:0] m_out,
    input  logic         m_put,
    output logic [1:0]   dbg_state
);

`ifdef SPI_XFER_GAP_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_GAP = 2'd2} state_t;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    logic [GW-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1} state_t;
`endif

    state_t       state_q, state_d;
    logic [1:0]   gnt_q, gnt_d;
    logic [1:0]   done_q, done_d;
    logic         last_q, last_d;   // last winner; also indexes the live grant
    logic [L-1:0] n_q, n_d;
    logic [L-1:0] tx_cnt_q, tx_cnt_d;
    logic [L-1:0] rx_cnt_q, rx_cnt_d;
    logic         tx_take, rx_take, winner;

    // Word path: route the granted requester to the master and gate both directions at n words.
    always_comb begin
        m_in           = last_q ? tx_data1 : tx_data0;
        rx_data        = m_out;
        m_empty        = (state_q != S_XFER) || !tx_valid[last_q] || (tx_cnt_q == n_q);
        tx_take        = m_get && !m_empty;
        rx_take        = (state_q == S_XFER) && m_put && (rx_cnt_q < n_q);
        tx_get         = 2'b00;
        rx_put         = 2'b00;
        tx_get[last_q] = tx_take;
        rx_put[last_q] = rx_take;
    end

    // Next-state: arbitration in IDLE, word counting and completion in XFER.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        last_d   = last_q;
        n_d      = n_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        winner   = last_q;
`ifdef SPI_XFER_GAP_EN
        gap_d    = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    // On a tie the requester that did not win last time goes next.
                    winner   = (req == 2'b11) ? ~last_q : req[1];
                    state_d  = S_XFER;
                    gnt_d    = winner ? 2'b10 : 2'b01;
                    last_d   = winner;
                    n_d      = winner ? len1 : len0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                end
            end
            S_XFER: begin
                tx_cnt_d = tx_cnt_q + {{(L-1){1'b0}}, tx_take};
                rx_cnt_d = rx_cnt_q + {{(L-1){1'b0}}, rx_take};
                // Completion is driven by the RX side: the last word has come back.
                if (rx_cnt_d == n_q) begin
                    done_d = gnt_q;
                    gnt_d  = 2'b00;
`ifdef SPI_XFER_GAP_EN
                    state_d = S_GAP;
                    gap_d   = GW'(G - 1);
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef SPI_XFER_GAP_EN
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            last_q   <= 1'b1;
            n_q      <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
`ifdef SPI_XFER_GAP_EN
            gap_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            last_q   <= last_d;
            n_q      <= n_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
`ifdef SPI_XFER_GAP_EN
            gap_q    <= gap_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
